ssd_score_display: RTL and testbench
====================================

Name: ssd_score_display

Overview:
Parametrised seven-segment scan controller for the Flappy score and debug readout, replacing the fixed two-digit scan mux in the top level. Accepts a binary value on a load strobe, converts it to BCD with a sequential double-dabble engine, and latches the result into a display register atomically. Time-multiplexes NUM_DIGITS active-low anodes with leading-zero blanking. Sits between the game core (score counter) and the board SSD pins.

Parameters:
NUM_DIGITS, 4, number of SSD digits scanned (1..8)
VALUE_W, 14, width of binary input value
SCAN_DIV_BITS, 18, digit dwell = 2^SCAN_DIV_BITS clk cycles (18 gives ~381 Hz per digit at 100 MHz)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
value  in  VALUE_W  binary value to display, sampled on accepted load
load  in  1  single-cycle strobe requesting conversion of value
blank_en  in  1  1 = suppress leading zeros
dp_mask  in  NUM_DIGITS  1 = light decimal point on that digit
busy  out  1  conversion in progress; load ignored while high
overflow  out  1  last accepted value exceeded 10^NUM_DIGITS-1
an  out  NUM_DIGITS  anodes, active-low, one-hot-low while scanning
seg  out  7  cathodes {a,b,c,d,e,f,g}, active-low
dp  out  1  decimal point cathode, active-low

Behaviour:
- Reset (async, reset_n=0): an all 1, seg 7'b1111111, dp 1, busy 0, overflow 0, display register 0, prescaler 0, digit index 0, FSM IDLE.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: load=1 -> capture value; if value > 10^NUM_DIGITS-1, capture clamp 10^NUM_DIGITS-1 and set ovf_pending; busy=1 next cycle; go SHIFT.
- SHIFT: VALUE_W cycles; each cycle add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1. Bit counter is ceil(log2(VALUE_W+1)) wide.
- COMMIT: one cycle; display register <= BCD result; overflow <= ovf_pending; busy <= 0; go IDLE.
- Load-to-display latency is VALUE_W+2 cycles. busy is high from the cycle after load through COMMIT inclusive.
- load while busy=1 is ignored; there is no queueing. load in the same cycle busy falls is ignored; a load the following cycle is accepted.
- Display register changes only in COMMIT, so no partially converted digit is ever shown.
- Scan: prescaler increments every cycle and wraps at 2^SCAN_DIV_BITS-1. On wrap, digit index increments modulo NUM_DIGITS. NUM_DIGITS need not be a power of 2: index NUM_DIGITS-1 wraps to 0.
- an/seg/dp are registered, one cycle behind the digit index.
- Blanking: digit i (i>0) is blanked (an bit 1, seg all 1) when blank_en=1 and digits i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. dp follows dp_mask even on blanked digits (anode off, so it stays dark).
- Decode table (0..9 decimal; A..F in hex mode): standard abcdefg active-low, e.g. 0 = 0000001, 1 = 1001111, 8 = 0000000.
- reset_n asserted mid-conversion aborts it: display returns to 0 and busy goes to 0.

Optional Feature:
SSD_HEX_MODE_EN: when defined, adds input hex_mode (1 bit).
- hex_mode=1 at load: value is shown as raw hex nibbles (low NUM_DIGITS*4 bits), with no BCD conversion. IDLE goes directly to COMMIT, giving 2-cycle latency. overflow=1 if any higher bits are nonzero.
- Not defined: no port, decimal-only, A..F entries unused.

Decomposition:
- Package ssd_pkg: FSM state enum; 7-bit segment constants SEG_0..SEG_F and SEG_OFF; function pow10(n) for the clamp constant; width helper clog2.
- Sub-module bin2bcd_seq: iterative double-dabble engine with start, busy, done and result. Instantiated once; the top handles clamping, display register, scan and decode.

Test Plan:
- Reset (NUM_DIGITS=4, SCAN_DIV_BITS=2): reset_n low mid-scan -> an=4'b1111, seg=7'h7F, busy=0 immediately; after release digit 0 shows seg=0000001.
- load value=1234 -> busy high 15 cycles (VALUE_W=14), display 1,2,3,4 on an[3..0] over 16 cycles; each anode low exactly 4 cycles.
- blank_en=1, value=7 -> an[3:1] never low, an[0] low 4 of every 16 cycles with seg=0001111; blank_en=0 -> digits 3..1 show 0.
- value=12000 -> display 9999, overflow=1; next load 42 -> overflow=0, display 0042.
- load 55, then load 99 two cycles later (busy) -> second ignored, display 55; load 99 after busy falls -> display 99.
- With SSD_HEX_MODE_EN, hex_mode=1, value=14'h2BEF -> display 2,B,E,F after 2 cycles, overflow=0.

Source files
------------

// File: rtl/ssd_score_display_pkg.sv
// Shared types, segment patterns and constant helpers for the seven-segment
// score display.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } ssd_state_e;

  // Cathodes {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ssd_score_display_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per clock,
// VALUE_W steps per conversion. done marks the cycle of the final step.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] result
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (run_q) begin
      bcd_d = (bcd_adj << 1) | BCD_W'(bin_q[VALUE_W-1]);
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      run_d = (cnt_q != CNT_W'(1));
    end else if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = CNT_W'(VALUE_W);
      run_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy   = run_q;
  assign done   = run_q && (cnt_q == CNT_W'(1));
  assign result = bcd_q;

endmodule

// File: rtl/ssd_score_display.sv
// Seven-segment scan controller: load -> clamp -> BCD -> atomic display latch,
// multiplexed active-low anodes with leading-zero blanking.
// Define SSD_HEX_MODE_EN to add the hex_mode input (raw hex display, no BCD).
//
//   state     | meaning
//   ST_IDLE   | waiting for load; captures value and overflow flag
//   ST_SHIFT  | double-dabble engine stepping through the value bits
//   ST_COMMIT | latch result into display register, publish overflow
module ssd_score_display
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 14,
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
`ifdef SSD_HEX_MODE_EN
  input  logic                  hex_mode,
`endif
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam int MAX_DEC = pow10(NUM_DIGITS) - 1;
  localparam int EXT_W   = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
`ifdef SSD_HEX_MODE_EN
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      4'hF: return SEG_F;
`endif
      default: return SEG_OFF;
    endcase
  endfunction

  logic hex_req;
`ifdef SSD_HEX_MODE_EN
  assign hex_req = hex_mode;
`else
  assign hex_req = 1'b0;
`endif

  ssd_state_e          state_q, state_d;
  logic                busy_q, busy_d, ovf_q, ovf_d, ovf_pend_q, ovf_pend_d;
  logic                hex_sel_q, hex_sel_d;
  logic [BCD_W-1:0]    hex_val_q, hex_val_d, disp_q, disp_d;
  logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, blank_vec;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic [31:0]         val_32;
  logic [EXT_W-1:0]    val_ext;
  logic [VALUE_W-1:0]  clamped;
  logic                dec_ovf, hex_ovf, eng_start, eng_busy, eng_done, zero_above;
  logic [BCD_W-1:0]    eng_result;
  logic [3:0]          nib;

  assign val_32    = 32'(value);
  assign dec_ovf   = val_32 > 32'(MAX_DEC);
  assign clamped   = dec_ovf ? VALUE_W'(MAX_DEC) : value;
  assign val_ext   = EXT_W'(value);
  assign hex_ovf   = |(val_ext >> BCD_W);
  assign eng_start = (state_q == ST_IDLE) && load && !hex_req;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (eng_start),
    .bin_in  (clamped),
    .busy    (eng_busy),
    .done    (eng_done),
    .result  (eng_result)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    hex_sel_d  = hex_sel_q;
    hex_val_d  = hex_val_q;
    disp_d     = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          busy_d    = 1'b1;
          hex_sel_d = hex_req;
          if (hex_req) begin
            hex_val_d  = val_ext[BCD_W-1:0];
            ovf_pend_d = hex_ovf;
            state_d    = ST_COMMIT;
          end else begin
            ovf_pend_d = dec_ovf;
            state_d    = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: if (eng_done || !eng_busy) state_d = ST_COMMIT;
      ST_COMMIT: begin
        disp_d  = hex_sel_q ? hex_val_q : eng_result;
        ovf_d   = ovf_pend_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan: blanking looks at the latched display only, never the engine.
  always_comb begin
    presc_d = presc_q + SCAN_DIV_BITS'(1);
    idx_d   = idx_q;
    if (&presc_q) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above & (disp_q[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_en & zero_above & (i != 0);
    end

    nib  = disp_q[{idx_q, 2'b00} +: 4];
    an_d = blank_vec[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank_vec[idx_q] ? SEG_OFF : seg_decode(nib);
    dp_d = ~dp_mask[idx_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      hex_sel_q  <= 1'b0;
      hex_val_q  <= '0;
      disp_q     <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      hex_sel_q  <= hex_sel_d;
      hex_val_q  <= hex_val_d;
      disp_q     <= disp_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_ssd_score_display.sv
// Self-checking bench for ssd_score_display (4 digits, 14-bit value, 4-cycle dwell).
module tb_ssd_score_display;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int BUSY_DEC = VW + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          blank_en = 1'b0;
  logic [ND-1:0] dp_mask = '0;
`ifdef SSD_HEX_MODE_EN
  logic          hex_mode = 1'b0;
`endif
  logic          busy, overflow, dp;
  logic [ND-1:0] an;
  logic [6:0]    seg;

  int n_pass = 0;
  int n_total = 0;

  ssd_score_display #(.NUM_DIGITS(ND), .VALUE_W(VW), .SCAN_DIV_BITS(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .blank_en (blank_en),
    .dp_mask  (dp_mask),
`ifdef SSD_HEX_MODE_EN
    .hex_mode (hex_mode),
`endif
    .busy     (busy),
    .overflow (overflow),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];

  typedef struct packed {
    logic [VW-1:0] v;
    logic          be;
    logic [3:0]    dm;
    logic [15:0]   bcd;
    logic [3:0]    blank;
    logic          ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  // Observe one full sweep (16 cycles) and check each digit's dwell and pattern.
  task automatic scan_check(input string nm, input logic [15:0] bcd,
                            input logic [3:0] blank, input logic [3:0] dm);
    int lows [4];
    int seg_err, dp_err, nlow, k;
    logic [3:0] d;
    seg_err = 0; dp_err = 0;
    for (int i = 0; i < 4; i++) lows[i] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      nlow = 0; k = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) begin nlow++; k = i; end
      if (nlow == 0) begin
        if (seg != 7'h7F) seg_err++;
      end else if (nlow == 1) begin
        lows[k]++;
        d = bcd[4*k +: 4];
        if (seg != seg_tab[d]) seg_err++;
        if (dp != ~dm[k]) dp_err++;
      end else seg_err++;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s an%0d low cycles", nm, i), lows[i], blank[i] ? 0 : 4);
    chk({nm, " seg errors"}, seg_err, 0);
    chk({nm, " dp errors"}, dp_err, 0);
  endtask

  task automatic do_load(input logic [VW-1:0] v, input logic be, input logic [3:0] dm,
                         input logic hx);
    @(negedge clk);
    value = v; blank_en = be; dp_mask = dm; load = 1'b1;
`ifdef SSD_HEX_MODE_EN
    hex_mode = hx;
`else
    if (hx) $display("note: hex request ignored in decimal build");
`endif
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_busy(input string nm, input int exp);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, n, exp);
  endtask

  task automatic run_vec(input string nm, input logic [VW-1:0] v, input logic be,
                         input logic [3:0] dm, input logic hx, input logic [15:0] bcd,
                         input logic [3:0] blank, input logic ovf, input int exp_busy);
    do_load(v, be, dm, hx);
    wait_busy(nm, exp_busy);
    chk({nm, " overflow"}, int'(overflow), int'(ovf));
    @(negedge clk);
    scan_check(nm, bcd, blank, dm);
  endtask

  // Reference: clamp, split into decimal digits, blank digits above the value's magnitude.
  function automatic void model(input int v, input bit be, output logic [15:0] bcd,
                                output logic [3:0] blank, output bit ovf);
    int c, p;
    ovf = (v > 9999);
    c = ovf ? 9999 : v;
    p = 1;
    bcd = '0;
    blank = '0;
    for (int i = 0; i < 4; i++) begin
      bcd[4*i +: 4] = 4'((c / p) % 10);
      if (i > 0 && be && c < p) blank[i] = 1'b1;
      p = p * 10;
    end
  endfunction

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
    seg_tab[15] = 7'b0111000;

    vecs[0]  = '{v:14'd1234,  be:1'b0, dm:4'b0000, bcd:16'h1234, blank:4'b0000, ovf:1'b0};
    vecs[1]  = '{v:14'd7,     be:1'b1, dm:4'b0000, bcd:16'h0007, blank:4'b1110, ovf:1'b0};
    vecs[2]  = '{v:14'd7,     be:1'b0, dm:4'b1000, bcd:16'h0007, blank:4'b0000, ovf:1'b0};
    vecs[3]  = '{v:14'd12000, be:1'b0, dm:4'b0000, bcd:16'h9999, blank:4'b0000, ovf:1'b1};
    vecs[4]  = '{v:14'd42,    be:1'b1, dm:4'b0010, bcd:16'h0042, blank:4'b1100, ovf:1'b0};
    vecs[5]  = '{v:14'd0,     be:1'b1, dm:4'b0001, bcd:16'h0000, blank:4'b1110, ovf:1'b0};
    vecs[6]  = '{v:14'd305,   be:1'b1, dm:4'b0000, bcd:16'h0305, blank:4'b1000, ovf:1'b0};
    vecs[7]  = '{v:14'd9999,  be:1'b1, dm:4'b1111, bcd:16'h9999, blank:4'b0000, ovf:1'b0};
    vecs[8]  = '{v:14'd10000, be:1'b1, dm:4'b0000, bcd:16'h9999, blank:4'b0000, ovf:1'b1};
    vecs[9]  = '{v:14'd1000,  be:1'b1, dm:4'b0100, bcd:16'h1000, blank:4'b0000, ovf:1'b0};
    vecs[10] = '{v:14'd16383, be:1'b0, dm:4'b0000, bcd:16'h9999, blank:4'b0000, ovf:1'b1};
    vecs[11] = '{v:14'd80,    be:1'b1, dm:4'b0000, bcd:16'h0080, blank:4'b1100, ovf:1'b0};

    // Reset state, asynchronous
    #2 reset_n = 1'b0;
    #1;
    chk("reset an", int'(an), 15);
    chk("reset seg", int'(seg), 127);
    chk("reset dp", int'(dp), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset overflow", int'(overflow), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    scan_check("after reset", 16'h0000, 4'b0000, 4'b0000);

    for (int i = 0; i < 12; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].v, vecs[i].be, vecs[i].dm, 1'b0,
              vecs[i].bcd, vecs[i].blank, vecs[i].ovf, BUSY_DEC);

    // Load while busy is dropped
    do_load(14'd55, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    value = 14'd99; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_busy("ignored load", BUSY_DEC - 2);
    @(negedge clk);
    scan_check("ignored load", 16'h0055, 4'b0000, 4'b0000);

    // Load during the commit cycle is dropped; the next cycle's load is taken
    do_load(14'd30, 1'b0, 4'b0000, 1'b0);
    repeat (14) @(negedge clk);
    value = 14'd77; load = 1'b1;
    @(negedge clk);
    chk("busy fall", int'(busy), 0);
    value = 14'd99;
    @(negedge clk);
    load = 1'b0;
    chk("reload accepted", int'(busy), 1);
    wait_busy("reload", BUSY_DEC);
    @(negedge clk);
    scan_check("reload", 16'h0099, 4'b0000, 4'b0000);

    // Reset mid-conversion after an overflowing load
    run_vec("pre-abort", 14'd12000, 1'b0, 4'b0000, 1'b0, 16'h9999, 4'b0000, 1'b1, BUSY_DEC);
    do_load(14'd1234, 1'b0, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort an", int'(an), 15);
    chk("abort seg", int'(seg), 127);
    chk("abort busy", int'(busy), 0);
    chk("abort overflow", int'(overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;
    scan_check("abort", 16'h0000, 4'b0000, 4'b0000);

    for (int r = 0; r < 16; r++) begin
      int v;
      bit be, ov;
      logic [3:0] dm, bl;
      logic [15:0] bcd;
      v  = (r % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      be = 1'($urandom % 2);
      dm = 4'($urandom % 16);
      model(v, be, bcd, bl, ov);
      run_vec($sformatf("rand%0d v=%0d", r, v), VW'(v), be, dm, 1'b0, bcd, bl, ov, BUSY_DEC);
    end

`ifdef SSD_HEX_MODE_EN
    run_vec("hex", 14'h2BEF, 1'b0, 4'b0101, 1'b1, 16'h2BEF, 4'b0000, 1'b0, 1);
    hex_mode = 1'b0;
    run_vec("back to dec", 14'd42, 1'b0, 4'b0000, 1'b0, 16'h0042, 4'b0000, 1'b0, BUSY_DEC);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
